spec_register_file: RTL and testbench



---
 rtl/spec_register_file.sv | 148 ++++++++++++++
 tb/tb_spec_register_file.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_register_file.sv
// Architectural register file with per-register speculative shadow copies and a dirty
// scoreboard; speculation is committed or discarded in a single cycle.
module spec_register_file #(
    parameter int DATABITWIDTH = 16,
    parameter int REGCOUNT     = 16,
    parameter int READPORTS    = 2,
    parameter int WRITEPORTS   = 2,
    localparam int ADDRW       = $clog2(REGCOUNT)
) (
    input  logic                               clk,
    input  logic                               async_rst,
    input  logic                               clk_en,
    input  logic                               Speculating,
    input  logic                               EndSpeculationPulse,
    input  logic                               MispredictedSpeculationPulse,
    input  logic [READPORTS*ADDRW-1:0]         ReadAddr,
    output logic [READPORTS*DATABITWIDTH-1:0]  ReadData,
    output logic [READPORTS-1:0]               ReadDirty,
    input  logic                               DirtySetEn,
    input  logic [ADDRW-1:0]                   DirtySetAddr,
    input  logic [WRITEPORTS-1:0]              WriteEn,
    input  logic [WRITEPORTS*ADDRW-1:0]        WriteAddr,
    input  logic [WRITEPORTS*DATABITWIDTH-1:0] WriteData,
    output logic [REGCOUNT-1:0]                DirtyVector,
    output logic [REGCOUNT-1:0]                SpecValidVector
);

    logic [DATABITWIDTH-1:0] committed     [REGCOUNT];
    logic [DATABITWIDTH-1:0] spec          [REGCOUNT];
    logic [DATABITWIDTH-1:0] committedNext [REGCOUNT];
    logic [DATABITWIDTH-1:0] specNext      [REGCOUNT];
    logic [DATABITWIDTH-1:0] writeVal      [REGCOUNT];
    logic [REGCOUNT-1:0]     specValid, specValidNext;
    logic [REGCOUNT-1:0]     dirty, dirtyNext;
    logic [REGCOUNT-1:0]     specDirty, specDirtyNext;
    logic [REGCOUNT-1:0]     writeHit;

    logic discard;
    logic commit;
    logic toSpec;
    logic writeDropped;

    // Mispredict dominates end-of-speculation; during either pulse nothing lands in Spec.
    assign discard      = MispredictedSpeculationPulse;
    assign commit       = EndSpeculationPulse && !discard;
    assign toSpec       = Speculating && !commit && !discard;
    assign writeDropped = discard && Speculating;

    // NOTE: combinational blocks use blocking '=' and assign every output first, so later
    // statements can override earlier ones without inferring a latch.
    always_comb begin : resolveWrites
        writeHit = '0;
        for (int r = 0; r < REGCOUNT; r++) begin
            writeVal[r] = '0;
            for (int p = 0; p < WRITEPORTS; p++) begin
                if (WriteEn[p] && WriteAddr[p*ADDRW +: ADDRW] == ADDRW'(r)) begin
                    writeHit[r] = 1'b1;
                    writeVal[r] = WriteData[p*DATABITWIDTH +: DATABITWIDTH];
                end
            end
        end
    end

    always_comb begin : nextState
        for (int r = 0; r < REGCOUNT; r++) begin
            committedNext[r] = committed[r];
            specNext[r]      = spec[r];
        end
        specValidNext = specValid;
        dirtyNext     = dirty;
        specDirtyNext = specDirty;

        if (discard) begin
            dirtyNext     = dirty & ~specDirty;
            specValidNext = '0;
            specDirtyNext = '0;
        end else if (commit) begin
            for (int r = 0; r < REGCOUNT; r++) begin
                if (specValid[r]) begin
                    committedNext[r] = spec[r];
                end
            end
            specValidNext = '0;
            specDirtyNext = '0;
        end

        // Write-clear first, then dirty-set, so a set wins on the same register.
        for (int r = 0; r < REGCOUNT; r++) begin
            if (writeHit[r] && !writeDropped) begin
                if (toSpec) begin
                    specNext[r]      = writeVal[r];
                    specValidNext[r] = 1'b1;
                end else begin
                    committedNext[r] = writeVal[r];
                end
                dirtyNext[r]     = 1'b0;
                specDirtyNext[r] = 1'b0;
            end
            if (DirtySetEn && !writeDropped && DirtySetAddr == ADDRW'(r)) begin
                dirtyNext[r] = 1'b1;
                if (toSpec) begin
                    specDirtyNext[r] = 1'b1;
                end
            end
        end

        committedNext[0] = '0;
        specNext[0]      = '0;
        specValidNext[0] = 1'b0;
        dirtyNext[0]     = 1'b0;
        specDirtyNext[0] = 1'b0;
    end

    // NOTE: the data arrays are reset too, because a reset must make every read return zero;
    // sequential state is updated with non-blocking '<=' only.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            for (int r = 0; r < REGCOUNT; r++) begin
                committed[r] <= '0;
                spec[r]      <= '0;
            end
            specValid <= '0;
            dirty     <= '0;
            specDirty <= '0;
        end else if (clk_en) begin
            for (int r = 0; r < REGCOUNT; r++) begin
                committed[r] <= committedNext[r];
                spec[r]      <= specNext[r];
            end
            specValid <= specValidNext;
            dirty     <= dirtyNext;
            specDirty <= specDirtyNext;
        end
    end

    always_comb begin : readPorts
        for (int p = 0; p < READPORTS; p++) begin
            ReadData[p*DATABITWIDTH +: DATABITWIDTH] =
                specValid[ReadAddr[p*ADDRW +: ADDRW]] ? spec[ReadAddr[p*ADDRW +: ADDRW]]
                                                      : committed[ReadAddr[p*ADDRW +: ADDRW]];
            ReadDirty[p] = dirty[ReadAddr[p*ADDRW +: ADDRW]];
        end
    end

    assign DirtyVector     = dirty;
    assign SpecValidVector = specValid;

endmodule

// File: tb/tb_spec_register_file.sv
// Self-checking bench for spec_register_file: directed scenarios plus random traffic
// compared against an architectural reference model of the register file.
`timescale 1ns/1ps
module tb_spec_register_file;

    localparam int DW = 16;
    localparam int RC = 16;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              async_rst;
    logic              clk_en;
    logic              Speculating;
    logic              EndSpeculationPulse;
    logic              MispredictedSpeculationPulse;
    logic [RP*AW-1:0]  ReadAddr;
    logic [RP*DW-1:0]  ReadData;
    logic [RP-1:0]     ReadDirty;
    logic              DirtySetEn;
    logic [AW-1:0]     DirtySetAddr;
    logic [WP-1:0]     WriteEn;
    logic [WP*AW-1:0]  WriteAddr;
    logic [WP*DW-1:0]  WriteData;
    logic [RC-1:0]     DirtyVector;
    logic [RC-1:0]     SpecValidVector;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state only.
    logic [DW-1:0] mCommitted [RC];
    logic [DW-1:0] mSpec      [RC];
    logic [RC-1:0] mSpecValid;
    logic [RC-1:0] mDirty;
    logic [RC-1:0] mSpecDirty;

    spec_register_file #(
        .DATABITWIDTH(DW), .REGCOUNT(RC), .READPORTS(RP), .WRITEPORTS(WP)
    ) dut (
        .clk(clk),
        .async_rst(async_rst),
        .clk_en(clk_en),
        .Speculating(Speculating),
        .EndSpeculationPulse(EndSpeculationPulse),
        .MispredictedSpeculationPulse(MispredictedSpeculationPulse),
        .ReadAddr(ReadAddr),
        .ReadData(ReadData),
        .ReadDirty(ReadDirty),
        .DirtySetEn(DirtySetEn),
        .DirtySetAddr(DirtySetAddr),
        .WriteEn(WriteEn),
        .WriteAddr(WriteAddr),
        .WriteData(WriteData),
        .DirtyVector(DirtyVector),
        .SpecValidVector(SpecValidVector)
    );

    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < RC; r++) begin
            mCommitted[r] = '0;
            mSpec[r]      = '0;
        end
        mSpecValid = '0;
        mDirty     = '0;
        mSpecDirty = '0;
    endtask

    function automatic logic [DW-1:0] modelRead(input int r);
        return mSpecValid[r] ? mSpec[r] : mCommitted[r];
    endfunction

    // One architectural clock step, applying the rules in their stated order.
    task automatic modelStep();
        logic intoSpec;
        logic dropAll;
        int   a;
        intoSpec = Speculating && !EndSpeculationPulse && !MispredictedSpeculationPulse;
        dropAll  = MispredictedSpeculationPulse && Speculating;
        if (MispredictedSpeculationPulse) begin
            mDirty     = mDirty & ~mSpecDirty;
            mSpecValid = '0;
            mSpecDirty = '0;
        end else if (EndSpeculationPulse) begin
            for (int r = 0; r < RC; r++)
                if (mSpecValid[r]) mCommitted[r] = mSpec[r];
            mSpecValid = '0;
            mSpecDirty = '0;
        end
        if (!dropAll) begin
            for (int p = 0; p < WP; p++) begin
                a = int'(WriteAddr[p*AW +: AW]);
                if (WriteEn[p] && a != 0) begin
                    if (intoSpec) begin
                        mSpec[a]      = WriteData[p*DW +: DW];
                        mSpecValid[a] = 1'b1;
                    end else begin
                        mCommitted[a] = WriteData[p*DW +: DW];
                    end
                    mDirty[a]     = 1'b0;
                    mSpecDirty[a] = 1'b0;
                end
            end
            a = int'(DirtySetAddr);
            if (DirtySetEn && a != 0) begin
                mDirty[a] = 1'b1;
                if (intoSpec) mSpecDirty[a] = 1'b1;
            end
        end
    endtask

    task automatic idle();
        Speculating                  = 1'b0;
        EndSpeculationPulse          = 1'b0;
        MispredictedSpeculationPulse = 1'b0;
        DirtySetEn                   = 1'b0;
        DirtySetAddr                 = '0;
        WriteEn                      = '0;
        WriteAddr                    = '0;
        WriteData                    = '0;
    endtask

    task automatic wr(input int p, input int addr, input logic [DW-1:0] d);
        WriteEn[p]             = 1'b1;
        WriteAddr[p*AW +: AW]  = AW'(addr);
        WriteData[p*DW +: DW]  = d;
    endtask

    task automatic checkVectors(input string tag);
        check({tag, " DirtyVector"}, 32'(DirtyVector), 32'(mDirty));
        check({tag, " SpecValidVector"}, 32'(SpecValidVector), 32'(mSpecValid));
    endtask

    task automatic readAll(input string tag);
        for (int r = 0; r < RC; r += RP) begin
            ReadAddr = {AW'(r + 1), AW'(r)};
            #0.5;
            for (int p = 0; p < RP; p++) begin
                check($sformatf("%s data r%0d", tag, r + p), 32'(ReadData[p*DW +: DW]),
                      32'(modelRead(r + p)));
                check($sformatf("%s dirty r%0d", tag, r + p), 32'(ReadDirty[p]),
                      32'(mDirty[r + p]));
            end
        end
    endtask

    task automatic readReg(input int r, output logic [DW-1:0] d);
        ReadAddr = {AW'(0), AW'(r)};
        #0.5;
        d = ReadData[DW-1:0];
    endtask

    // Clock edge, model update, then a full comparison of all visible state.
    task automatic tick(input string tag);
        @(posedge clk);
        if (clk_en && !async_rst) modelStep();
        #1;
        checkVectors(tag);
        readAll(tag);
        idle();
    endtask

    initial begin
        logic [DW-1:0] d;
        idle();
        clk_en    = 1'b0;
        ReadAddr  = '0;
        async_rst = 1'b0;
        modelReset();
        #3 async_rst = 1'b1;
        #2;
        checkVectors("reset");
        readAll("reset");

        @(negedge clk);
        async_rst = 1'b0;
        clk_en    = 1'b1;

        wr(0, 3, 16'h1234);
        tick("write r3");
        readReg(3, d);
        check("plan r3", 32'(d), 32'h1234);
        check("plan r3 specvalid", 32'(SpecValidVector), 32'h0);

        wr(0, 5, 16'hAAAA);
        wr(1, 5, 16'h5555);
        tick("conflict r5");
        readReg(5, d);
        check("plan r5 priority", 32'(d), 32'h5555);
        wr(1, 0, 16'hFFFF);
        tick("write r0");
        readReg(0, d);
        check("plan r0 zero", 32'(d), 32'h0);

        wr(0, 2, 16'h0011);
        tick("commit base");
        Speculating = 1'b1;
        wr(0, 2, 16'h0022);
        tick("commit spec");
        readReg(2, d);
        check("plan r2 spec", 32'(d), 32'h0022);
        check("plan r2 specvalid", 32'(SpecValidVector[2]), 32'h1);
        EndSpeculationPulse = 1'b1;
        wr(0, 2, 16'h0033);
        tick("commit end");
        readReg(2, d);
        check("plan r2 committed", 32'(d), 32'h0033);
        check("plan commit specvalid", 32'(SpecValidVector), 32'h0);

        wr(0, 4, 16'h0044);
        DirtySetEn   = 1'b1;
        DirtySetAddr = 4'd7;
        tick("rollback base");
        Speculating  = 1'b1;
        DirtySetEn   = 1'b1;
        DirtySetAddr = 4'd6;
        wr(0, 4, 16'h0099);
        tick("rollback spec");
        MispredictedSpeculationPulse = 1'b1;
        tick("rollback mispredict");
        readReg(4, d);
        check("plan r4 restored", 32'(d), 32'h0044);
        check("plan dirty6 cleared", 32'(DirtyVector[6]), 32'h0);
        check("plan dirty7 kept", 32'(DirtyVector[7]), 32'h1);
        check("plan rollback specvalid", 32'(SpecValidVector), 32'h0);

        wr(0, 8, 16'h0008);
        tick("both base");
        Speculating = 1'b1;
        wr(1, 8, 16'h0808);
        tick("both spec");
        EndSpeculationPulse          = 1'b1;
        MispredictedSpeculationPulse = 1'b1;
        tick("both pulses");
        readReg(8, d);
        check("plan r8 discard", 32'(d), 32'h0008);

        for (int i = 0; i < 300; i++) begin
            clk_en                       = ($urandom_range(9) != 0);
            Speculating                  = 1'($urandom);
            EndSpeculationPulse          = ($urandom_range(7) == 0);
            MispredictedSpeculationPulse = ($urandom_range(9) == 0);
            DirtySetEn                   = 1'($urandom);
            DirtySetAddr                 = AW'($urandom);
            WriteEn                      = WP'($urandom);
            WriteAddr                    = (WP*AW)'($urandom);
            WriteData                    = (WP*DW)'($urandom);
            tick($sformatf("rand%0d", i));
        end

        clk_en      = 1'b1;
        Speculating = 1'b1;
        wr(0, 9, 16'h9999);
        DirtySetEn   = 1'b1;
        DirtySetAddr = 4'd10;
        tick("hold setup");
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Speculating                  = 1'($urandom);
            EndSpeculationPulse          = (i == 0);
            MispredictedSpeculationPulse = (i == 1);
            DirtySetEn                   = 1'b1;
            DirtySetAddr                 = AW'(i + 11);
            wr(0, 9, 16'h1111);
            wr(1, i + 11, 16'h2222);
            tick($sformatf("hold%0d", i));
        end
        readReg(9, d);
        check("plan r9 held", 32'(d), 32'h9999);

        async_rst = 1'b1;
        modelReset();
        #1;
        checkVectors("midspec reset");
        readAll("midspec reset");
        check("plan reset specvalid", 32'(SpecValidVector), 32'h0);
        check("plan reset dirty", 32'(DirtyVector), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
